// File: rtl/tt_um_hoene_manchester_encoder.sv
// Manchester re-encoder for a daisy-chained LED string: forwards decoded bits
// through a 4-deep FIFO and re-emits them at the half-bit width seen upstream.
module tt_um_hoene_manchester_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_data,
  input  logic       in_clk,
  input  logic       in_error,
  input  logic [5:0] in_pulsewidth,
  input  logic       in_forward,
  output logic       out,
  output logic       out_busy,
  output logic       out_overflow,
  output logic [1:0] dbg_state_o
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] FIRST_HALF  = 2'd1;
  localparam logic [1:0] SECOND_HALF = 2'd2;

  logic [3:0] fifo_q;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] count_q, count_d;
  logic [1:0] state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] w_q, w_d;
  logic       bit_q, bit_d;
  logic       out_q, out_d;
  logic       busy_q, busy_d;
  logic       ovf_q, ovf_d;

  logic       fsm_pop;
  logic       pop;
  logic       push;
  logic       push_req;
  logic [5:0] w_in;
  logic       head;

  assign w_in     = (in_pulsewidth == 6'd0) ? 6'd1 : in_pulsewidth;
  assign head     = fifo_q[rd_ptr_q];
  assign push_req = in_clk & in_forward & ~in_error;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    bit_d   = bit_q;
    out_d   = out_q;
    fsm_pop = 1'b0;
    case (state_q)
      IDLE: begin
        out_d = 1'b0;
        if (count_q != 3'd0) begin
          fsm_pop = 1'b1;
          state_d = FIRST_HALF;
          w_d     = w_in;
          cnt_d   = w_in - 6'd1;
          bit_d   = head;
          out_d   = head;
        end
      end
      FIRST_HALF: begin
        if (cnt_q == 6'd0) begin
          state_d = SECOND_HALF;
          cnt_d   = w_q - 6'd1;
          out_d   = ~bit_q;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      SECOND_HALF: begin
        if (cnt_q != 6'd0) begin
          cnt_d = cnt_q - 6'd1;
        end else if (count_q != 3'd0) begin
          // Next bit starts on the same edge so the line has no idle gap.
          fsm_pop = 1'b1;
          state_d = FIRST_HALF;
          w_d     = w_in;
          cnt_d   = w_in - 6'd1;
          bit_d   = head;
          out_d   = head;
        end else begin
          state_d = IDLE;
          out_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = 1'b0;
      end
    endcase

    pop  = fsm_pop & ~in_error;
    push = push_req & ((count_q != 3'd4) | pop);
    ovf_d = ovf_q | (push_req & (count_q == 3'd4) & ~pop);

    rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    // A line error discards everything, including any bit being pushed now.
    if (in_error) begin
      state_d  = IDLE;
      out_d    = 1'b0;
      cnt_d    = 6'd0;
      count_d  = 3'd0;
      rd_ptr_d = 2'd0;
      wr_ptr_d = 2'd0;
    end

    busy_d = (state_d != IDLE) | (count_d != 3'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_q   <= 4'd0;
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      w_q      <= 6'd1;
      bit_q    <= 1'b0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= in_data;
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      w_q      <= w_d;
      bit_q    <= bit_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out          = out_q;
  assign out_busy     = busy_q;
  assign out_overflow = ovf_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_tt_um_hoene_manchester_encoder.sv
// Bench for the Manchester re-encoder: line samples are predicted per pushed bit
// into exp_q and compared cycle by cycle as the DUT transmits.
module tb_tt_um_hoene_manchester_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_data;
  logic       in_clk;
  logic       in_error;
  logic [5:0] in_pulsewidth;
  logic       in_forward;
  logic       out;
  logic       out_busy;
  logic       out_overflow;
  logic [1:0] dbg_state;

  tt_um_hoene_manchester_encoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_data       (in_data),
    .in_clk        (in_clk),
    .in_error      (in_error),
    .in_pulsewidth (in_pulsewidth),
    .in_forward    (in_forward),
    .out           (out),
    .out_busy      (out_busy),
    .out_overflow  (out_overflow),
    .dbg_state_o   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  int total = 0;
  int bad   = 0;

  // bit 1 set = don't-care slot, bit 0 = expected line level
  logic [1:0] exp_q[$];

  typedef struct {
    logic       data;
    logic [5:0] pw;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // One clock: wait for the falling edge, then check the scoreboard head.
  task automatic tick();
    logic [1:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!e[1]) check("line", {7'd0, out}, {7'd0, e[0]});
    end
  endtask

  function automatic int width_of(input logic [5:0] pw);
    return (pw == 6'd0) ? 1 : int'(pw);
  endfunction

  task automatic enqueue_bit(input logic b, input logic [5:0] pw);
    int w;
    w = width_of(pw);
    if (exp_q.size() == 0) exp_q.push_back(2'b10);
    for (int i = 0; i < w; i++) exp_q.push_back({1'b0, b});
    for (int i = 0; i < w; i++) exp_q.push_back({1'b0, ~b});
  endtask

  // driver: strobe one bit across the next rising edge
  task automatic send(input logic b, input logic [5:0] pw, input bit accept);
    in_data       = b;
    in_pulsewidth = pw;
    in_forward    = 1'b1;
    in_clk        = 1'b1;
    if (accept) enqueue_bit(b, pw);
    tick();
    in_clk = 1'b0;
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("drain_done", {7'd0, exp_q.size() == 0}, 8'd1);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    check("rst_out", {7'd0, out}, 8'd0);
    check("rst_busy", {7'd0, out_busy}, 8'd0);
    check("rst_ovf", {7'd0, out_overflow}, 8'd0);
    check("rst_state", {6'd0, dbg_state}, 8'd0);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic check_idle(input string name, input logic want_ovf);
    check({name, "_out"}, {7'd0, out}, 8'd0);
    check({name, "_busy"}, {7'd0, out_busy}, 8'd0);
    check({name, "_ovf"}, {7'd0, out_overflow}, {7'd0, want_ovf});
  endtask

  logic [5:0] ovf_bits;
  logic [6:0] full_bits;

  initial begin
    vecs[0] = '{data: 1'b1, pw: 6'd4};
    vecs[1] = '{data: 1'b0, pw: 6'd4};
    vecs[2] = '{data: 1'b1, pw: 6'd2};
    vecs[3] = '{data: 1'b0, pw: 6'd1};
    vecs[4] = '{data: 1'b1, pw: 6'd0};
    vecs[5] = '{data: 1'b0, pw: 6'd0};
    vecs[6] = '{data: 1'b1, pw: 6'd63};
    vecs[7] = '{data: 1'b0, pw: 6'd7};
    ovf_bits  = 6'b101101;
    full_bits = 7'b0110101;

    rst_n = 1'b0; in_data = 1'b0; in_clk = 1'b0; in_error = 1'b0;
    in_pulsewidth = 6'd0; in_forward = 1'b0;
    tick();
    do_reset();

    // single bits from the table, each followed by a return to idle
    for (int v = 0; v < 8; v++) begin
      send(vecs[v].data, vecs[v].pw, 1'b1);
      check("busy_after_push", {7'd0, out_busy}, 8'd1);
      drain(300);
      tick();
      check_idle("after_bit", 1'b0);
    end

    // back-to-back 0 then 1 at pw=2: 0,0,1,1,1,1,0,0
    send(1'b0, 6'd2, 1'b1);
    send(1'b1, 6'd2, 1'b1);
    drain(50);
    tick();
    check_idle("b2b", 1'b0);

    // forwarding disabled: strobes are ignored
    in_forward = 1'b0;
    in_data    = 1'b1;
    in_pulsewidth = 6'd3;
    for (int i = 0; i < 6; i++) begin
      in_clk = (i < 3);
      tick();
      check_idle("gated", 1'b0);
    end
    in_clk = 1'b0;

    // pw=10, six bits in a row: sixth one is dropped
    for (int i = 0; i < 6; i++) begin
      send(ovf_bits[i], 6'd10, i < 5);
      check("ovf_edge", {7'd0, out_overflow}, {7'd0, i == 5});
    end
    drain(200);
    tick();
    check_idle("ovf_end", 1'b1);
    repeat (3) tick();
    check("ovf_sticky", {7'd0, out_overflow}, 8'd1);

    // error mid-first-half with three bits queued
    for (int i = 0; i < 3; i++) send(ovf_bits[i], 6'd8, 1'b0);
    tick();
    tick();
    check("err_pre_out", {7'd0, out}, {7'd0, ovf_bits[0]});
    in_error = 1'b1;
    in_clk   = 1'b1;
    tick();
    in_error = 1'b0;
    in_clk   = 1'b0;
    check_idle("err", 1'b1);
    check("err_state", {6'd0, dbg_state}, 8'd0);
    repeat (20) tick();
    check_idle("err_later", 1'b1);

    // same situation, cut short by reset instead
    for (int i = 0; i < 3; i++) send(ovf_bits[i], 6'd8, 1'b0);
    tick();
    tick();
    do_reset();
    repeat (20) tick();
    check_idle("rst_later", 1'b0);

    // pw=2, seven bits in a row: a push into a full FIFO during a pop is kept,
    // the next one into a full FIFO is dropped
    for (int i = 0; i < 7; i++) begin
      send(full_bits[i], 6'd2, i < 6);
      check("full_edge_ovf", {7'd0, out_overflow}, {7'd0, i == 6});
    end
    drain(100);
    tick();
    check_idle("full_end", 1'b1);

    do_reset();
    send(1'b1, 6'd3, 1'b1);
    drain(50);
    tick();
    check_idle("final", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tt_um_hoene_manchester_encoder.md
TT_UM_HOENE_MANCHESTER_ENCODER -- requirements
Module: tt_um_hoene_manchester_encoder

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have port in_data, input, 1 bit: decoded data bit from the Manchester decoder.
REQ-004 The block SHALL have port in_clk, input, 1 bit: one-cycle strobe; in_data is valid when it is high.
REQ-005 The block SHALL have port in_error, input, 1 bit: decoder error strobe.
REQ-006 The block SHALL have port in_pulsewidth, input, 6 bits: half-bit period in clk cycles, as measured by the decoder.
REQ-007 The block SHALL have port in_forward, input, 1 bit: high once this LED has consumed its own word; subsequent bits are forwarded.
REQ-008 The block SHALL have port out, output, 1 bit: registered Manchester line to the next LED in the chain.
REQ-009 The block SHALL have port out_busy, output, 1 bit: high while a bit is being sent or the FIFO is non-empty.
REQ-010 The block SHALL have port out_overflow, output, 1 bit: sticky flag for a dropped bit.

Function
REQ-011 The block SHALL buffer bits in a 4-entry FIFO with a 2-bit read pointer, a 2-bit write pointer (both wrap 3->0) and a 3-bit count (0..4).
REQ-012 The FIFO SHALL push when in_clk=1 and in_forward=1 and in_error=0, and either count<4 or a pop occurs on the same edge.
REQ-013 When a push is requested while count=4 and no pop occurs on that edge, the bit SHALL be dropped, out_overflow SHALL be set to 1, and out_overflow SHALL stay 1 until reset.
REQ-014 When a push and a pop occur on the same edge, count SHALL be unchanged and both pointers SHALL advance.
REQ-015 The encoder SHALL be an FSM with states IDLE, FIRST_HALF and SECOND_HALF, plus a 6-bit down-counter.
REQ-016 At each bit load, the FSM SHALL latch the half period as W = in_pulsewidth, with in_pulsewidth=0 treated as W=1; the latched W SHALL hold for the whole bit.
REQ-017 In IDLE with count>0, the FSM SHALL on that same edge pop the head bit, set the counter to W-1, enter FIRST_HALF, and set out to the first-half level.
REQ-018 Encoding SHALL be: bit 1 -> first half high, second half low; bit 0 -> first half low, second half high.
REQ-019 In FIRST_HALF at counter=0, the FSM SHALL enter SECOND_HALF, reload the counter with W-1, and set out to the second-half level; otherwise the counter SHALL decrement.
REQ-020 In SECOND_HALF at counter=0 with count>0, the FSM SHALL pop directly into FIRST_HALF with no idle gap.
REQ-021 In SECOND_HALF at counter=0 with count=0, the FSM SHALL enter IDLE and set out to 0.
REQ-022 Each half SHALL last exactly W cycles.
REQ-023 Latency SHALL be: a bit pushed into an empty, idle block at edge N appears on out (first half) after edge N+1.
REQ-024 In IDLE, out SHALL be 0.
REQ-025 in_forward=0 SHALL only block new pushes; a bit in progress and bits already buffered SHALL still be sent.
REQ-026 in_error=1 SHALL on that edge flush the FIFO (count=0, pointers=0), set the FSM to IDLE and set out to 0; it SHALL take priority over a simultaneous push or pop, and the dropped bit SHALL NOT set out_overflow.
REQ-027 out_busy SHALL be registered, equal to (next state != IDLE) or (next count != 0).

Reset
REQ-028 While rst_n=0 at a clock edge: out=0, out_busy=0, out_overflow=0, FSM=IDLE, count=0, pointers=0, counter=0, latched W=1.
REQ-029 Reset SHALL take effect on the next edge even mid-bit or mid-FIFO; no partial bit SHALL be resumed afterwards.

Verification
REQ-030 Single bit: pw=4, forward=1, push bit 1 at edge N -> out=1 for edges N+1..N+4 window, out=0 for the next 4 cycles, then idle low; out_busy falls after the bit ends.
REQ-031 Back-to-back: pw=2, push 0 then 1 on consecutive edges -> out sequence 0,0,1,1,1,1,0,0 with no gap; overflow stays 0.
REQ-032 Overflow: pw=10, push 6 bits on 6 consecutive edges -> bits 1-5 are sent, bit 6 is dropped, out_overflow=1 and remains 1 after the transmission ends.
REQ-033 Gating and width: forward=0 with 3 strobes -> out stays 0 and out_busy stays 0; then pw=0, forward=1, push 1 -> out high 1 cycle, low 1 cycle.
REQ-034 Error/reset: pw=8, 3 bits buffered, mid-first-half assert in_error -> out=0 and busy=0 next cycle, overflow unchanged; repeat with rst_n=0 instead -> all outputs 0 next cycle.
